apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master_if.sv | 27 ++
 rtl/apb_cmd_master.sv | 121 ++++++++++++
 tb/tb_apb_cmd_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// APB bus bundle between apb_cmd_master and an APB completer.
// The master modport drives the request side; the slave modport returns pready/prdata/pslverr.
interface apb_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    pselx;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output paddr, pprot, pselx, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, pselx, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-command APB master: IDLE -> SETUP -> ACCESS, with a one-cycle done pulse.
// Define APB_TIMEOUT_EN to add an ACCESS-phase wait-state limit of TIMEOUT_CYC cycles.
module apb_cmd_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic [2:0]              cmd_prot,
  output logic                    ready,
  output logic                    idle,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    err,
  output logic                    timeout,
  apb_cmd_master_if.master        apb
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYC must be in 2..65535");
  end
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
    $error("apb_cmd_master: DATA_WIDTH must be 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t state;

`ifdef APB_TIMEOUT_EN
  logic [15:0] wait_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ready       <= 1'b1;
      idle        <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      rd_data     <= '0;
      apb.paddr   <= '0;
      apb.pprot   <= '0;
      apb.pselx   <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.pwdata  <= '0;
      apb.pstrb   <= '0;
`ifdef APB_TIMEOUT_EN
      timeout     <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            apb.paddr  <= cmd_addr;
            apb.pprot  <= cmd_prot;
            apb.pwrite <= cmd_write;
            apb.pwdata <= cmd_wdata;
            // reads never carry byte strobes onto the bus
            apb.pstrb  <= cmd_write ? cmd_wstrb : '0;
            apb.pselx  <= 1'b1;
            ready      <= 1'b0;
            idle       <= 1'b0;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          apb.penable <= 1'b1;
          state       <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        S_ACCESS: begin
          if (apb.pready) begin
            if (!apb.pwrite) rd_data <= apb.prdata;
            err         <= apb.pslverr;
            done        <= 1'b1;
            apb.pselx   <= 1'b0;
            apb.penable <= 1'b0;
            ready       <= 1'b1;
            idle        <= 1'b1;
            state       <= S_IDLE;
`ifdef APB_TIMEOUT_EN
            timeout     <= 1'b0;
          end else if (wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
            // this stalled cycle is the TIMEOUT_CYC-th one: abort without touching rd_data
            err         <= 1'b1;
            timeout     <= 1'b1;
            done        <= 1'b1;
            apb.pselx   <= 1'b0;
            apb.penable <= 1'b0;
            ready       <= 1'b1;
            idle        <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt    <= wait_cnt + 16'd1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized bench for apb_cmd_master against a transaction-level model of expected
// latency, bus contents and completion status.
module tb_apb_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          ready, idle, done, err, timeout;
  logic [DW-1:0] rd_data;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_rd = '0;
  logic          exp_err = 1'b0;

  apb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
    .ready(ready), .idle(idle), .done(done), .rd_data(rd_data), .err(err),
    .timeout(timeout), .apb(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command; the slave inserts `waits` stall cycles and then completes.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input bit slverr, input logic [31:0] rdata);
    int cyc, n_setup, n_acc;
    bit got, last;
    logic [3:0] exp_strb;
    exp_strb = wr ? strb : 4'h0;
    chk("ready_before_start", ready, 1);
    start = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_wstrb = strb; cmd_prot = prot;
    tick();
    start = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom); cmd_prot = 3'($urandom);
    cyc = 0; n_setup = 0; n_acc = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      cyc++;
      if (done) got = 1'b1;
      else begin
        chk("busy_ready_idle", {ready, idle}, 2'b00);
        chk("paddr", bus.paddr, addr);
        chk("pwrite", bus.pwrite, wr);
        chk("pwdata", bus.pwdata, wdata);
        chk("pstrb", bus.pstrb, exp_strb);
        chk("pprot", bus.pprot, prot);
        if (bus.pselx && !bus.penable) begin
          n_setup++;
          bus.pready = 1'($urandom); bus.pslverr = 1'($urandom); bus.prdata = $urandom;
        end else if (bus.pselx && bus.penable) begin
          last = (n_acc == waits);
          bus.pready  = last;
          bus.prdata  = last ? rdata : $urandom;
          bus.pslverr = last ? slverr : 1'($urandom);
          n_acc++;
        end else begin
          chk("busy_phase_psel_pen", {bus.pselx, bus.penable}, 2'b11);
        end
        tick();
      end
    end
    bus.pready = 1'b0; bus.pslverr = 1'b0;
    if (!wr) exp_rd = rdata;
    exp_err = slverr;
    chk("done_seen", got, 1);
    chk("latency", cyc, 3 + waits);
    chk("setup_cycles", n_setup, 1);
    chk("access_cycles", n_acc, waits + 1);
    chk("done_psel_pen", {bus.pselx, bus.penable}, 2'b00);
    chk("done_ready_idle", {ready, idle}, 2'b11);
    chk("done_err", err, exp_err);
    chk("done_timeout", timeout, 0);
    chk("done_rd_data", rd_data, exp_rd);
    chk("idle_paddr_hold", bus.paddr, addr);
    chk("idle_pstrb_hold", bus.pstrb, exp_strb);
  endtask

  task automatic idle_gap();
    tick();
    chk("gap_done_low", done, 0);
    chk("gap_psel", bus.pselx, 0);
    chk("gap_ready_idle", {ready, idle}, 2'b11);
    chk("gap_err_hold", err, exp_err);
    chk("gap_rd_hold", rd_data, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr, slv, got;
    int waits, cyc, n_done;
    logic [8:0] psel_seq, done_seq;

    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
    #12;
    chk("rst_ready_idle", {ready, idle}, 2'b11);
    chk("rst_done_err_to", {done, err, timeout}, 3'b000);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_psel_pen", {bus.pselx, bus.penable, bus.pwrite}, 3'b000);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_pstrb_pprot", {bus.pstrb, bus.pprot}, 0);
    @(posedge clk); #1; rst = 1'b0;

    xfer(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 3'd0, 0, 1'b0, 32'h0);
    xfer(1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'd2, 2, 1'b0, 32'h1234_5678);
    xfer(1'b1, 32'h30, 32'h0BAD_F00D, 4'h3, 3'd1, 0, 1'b1, 32'h0);
    chk("slverr_err", err, 1);
    xfer(1'b0, 32'h34, 32'h0, 4'h0, 3'd0, 1, 1'b0, 32'hCAFE_0001);
    chk("err_cleared", err, 0);
    idle_gap();

    for (int i = 0; i < 25; i++) begin
      wr = 1'($urandom); slv = 1'($urandom); waits = $urandom_range(0, 3);
      xfer(wr, $urandom, $urandom, 4'($urandom), 3'($urandom), waits, slv, $urandom);
      if ($urandom_range(0, 2) == 0) idle_gap();
    end
    idle_gap();

    // start held high: exactly two transfers, pselx low for one cycle between them
    bus.pready = 1'b1;
    cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    start = 1'b1;
    psel_seq = '0; done_seq = '0; n_done = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      psel_seq[k-1] = bus.pselx;
      done_seq[k-1] = done;
      if (done) n_done++;
      if (k == 6) start = 1'b0;
    end
    bus.pready = 1'b0;
    exp_err = 1'b0;
    chk("b2b_done_count", n_done, 2);
    chk("b2b_psel_seq", psel_seq, 9'b000011011);
    chk("b2b_done_seq", done_seq, 9'b000100100);
    chk("b2b_rd_hold", rd_data, exp_rd);

    // slave never ready
    cmd_write = 1'b0; cmd_addr = 32'h50; start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 100) begin
      bus.prdata = $urandom;
      tick();
      cyc++;
      if (done) got = 1'b1;
    end
`ifdef APB_TIMEOUT_EN
    exp_err = 1'b1;
    chk("to_done", got, 1);
    chk("to_latency", cyc, TO + 1);
    chk("to_err_timeout", {err, timeout}, 2'b11);
    chk("to_rd_hold", rd_data, exp_rd);
    chk("to_psel_pen", {bus.pselx, bus.penable}, 2'b00);
`else
    chk("stall_no_done", got, 0);
    chk("stall_psel_pen", {bus.pselx, bus.penable}, 2'b11);
    bus.pready = 1'b1; bus.prdata = 32'h0F0F_1234;
    tick();
    bus.pready = 1'b0;
    exp_rd = 32'h0F0F_1234; exp_err = 1'b0;
    chk("stall_release_done", done, 1);
    chk("stall_release_rd", rd_data, exp_rd);
`endif
    idle_gap();

    // reset asserted between edges while in ACCESS
    cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h1111_2222; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_access", {bus.pselx, bus.penable}, 2'b11);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_psel_pen_done", {bus.pselx, bus.penable, done}, 3'b000);
    chk("rst_mid_ready_idle", {ready, idle}, 2'b11);
    chk("rst_mid_rd_err", {rd_data, err}, 0);
    chk("rst_mid_paddr", bus.paddr, 0);
    exp_rd = '0; exp_err = 1'b0;
    tick();
    rst = 1'b0;
    bus.pready = 1'b1;
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      if (done || bus.pselx) n_done++;
      tick();
    end
    bus.pready = 1'b0;
    chk("rst_no_done_after", n_done, 0);
    xfer(1'b0, 32'h70, 32'h0, 4'h0, 3'd5, 1, 1'b0, 32'h7777_8888);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
